// File: rtl/spram_fifo_ctrl_pkg.sv
// Shared sizing constants and types for the single-port-RAM FIFO controller.
// The controller is sized for the 128x4 RAM it drives; DEPTH is always 2**AW.
package spram_fifo_pkg;

    localparam int AW    = 7;
    localparam int DW    = 4;
    localparam int DEPTH = 2 ** AW;

    // Which requester won the RAM port on the most recent granted cycle.
    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } gnt_t;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   level_t;
    typedef logic [DW-1:0] data_t;

    localparam level_t LEVEL_FULL = level_t'(DEPTH);

endpackage : spram_fifo_pkg

// File: rtl/spram_fifo_ctrl_rr_arb2.sv
// Two-way round-robin grant for the shared RAM port: read versus write.
// A contested cycle goes to whichever side did not win the previous grant.
module spram_rr_arb2
    import spram_fifo_pkg::*;
(
    input  logic i_want_rd,
    input  logic i_want_wr,
    input  gnt_t i_last_gnt,
    output logic o_rd_sel,
    output logic o_wr_sel
);

    logic w_rd_turn;

    assign w_rd_turn = (i_last_gnt == GNT_WR);
    assign o_rd_sel  = i_want_rd & (!i_want_wr | w_rd_turn);
    assign o_wr_sel  = i_want_wr & !o_rd_sel;

endmodule : spram_rr_arb2

// File: rtl/spram_fifo_ctrl.sv
// Valid/ready FIFO controller in front of a 128x4 single-port RAM.
// Writes and reads share the port; read words land in a one-entry output slot.
module spram_fifo_ctrl
    import spram_fifo_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [AW:0]   ram_level,
    output logic          ram_enb,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    ptr_t   r_wr_ptr;
    ptr_t   r_rd_ptr;
    level_t r_ram_level;
    logic   r_out_valid;
    data_t  r_out_data;
    gnt_t   r_last_gnt;

    logic   w_slot_free;
    logic   w_full;
    logic   w_want_rd;
    logic   w_want_wr;
    logic   w_rd_sel;
    logic   w_wr_sel;

    assign w_slot_free = !r_out_valid | out_ready;
    assign w_full      = (r_ram_level == LEVEL_FULL);
    assign w_want_rd   = (r_ram_level != '0) & w_slot_free;
    assign w_want_wr   = in_valid & !w_full;

    spram_rr_arb2 u_arb (
        .i_want_rd  (w_want_rd),
        .i_want_wr  (w_want_wr),
        .i_last_gnt (r_last_gnt),
        .o_rd_sel   (w_rd_sel),
        .o_wr_sel   (w_wr_sel)
    );

    // A non-write cycle always presents rd_ptr, so an idle cycle is a harmless read.
    always_comb begin
        ram_enb   = 1'b0;
        ram_addr  = r_rd_ptr;
        ram_wdata = '0;
        if (w_wr_sel) begin
            ram_enb   = 1'b1;
            ram_addr  = r_wr_ptr;
            ram_wdata = in_data;
        end
    end

    assign in_ready  = !w_full & !w_rd_sel;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign ram_level = r_ram_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_sel) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            end
            if (w_rd_sel) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
        end
    end

    // Read and write are mutually exclusive, so the level moves by at most one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ram_level <= '0;
            r_last_gnt  <= GNT_RD;
        end else if (w_wr_sel) begin
            r_ram_level <= r_ram_level + level_t'(1);
            r_last_gnt  <= GNT_WR;
        end else if (w_rd_sel) begin
            r_ram_level <= r_ram_level - level_t'(1);
            r_last_gnt  <= GNT_RD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_rd_sel) begin
            r_out_valid <= 1'b1;
            r_out_data  <= ram_rdata;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    a_level_in_range : assert property (
        @(posedge clk) disable iff (!rst) (r_ram_level <= LEVEL_FULL)
    );

    a_no_read_when_empty : assert property (
        @(posedge clk) disable iff (!rst) (w_rd_sel |-> (r_ram_level != '0))
    );

endmodule : spram_fifo_ctrl

// File: doc/spram_fifo_ctrl.md
Name: spram_fifo_ctrl

Overview:
Streaming FIFO controller that sits directly upstream of the 128x4 single-port RAM. It turns an in/out valid-ready stream pair into RAM cycles: enb=1 writes, enb=0 reads combinationally. Write and read requests share the single port through a 2-way round-robin grant. Read words are registered into a one-entry output slot.

Parameters:
AW, 7, RAM address width.
DW, 4, data width.
DEPTH, 128, RAM depth; always 2**AW.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
in_valid  input  1  upstream word available.
in_data  input  DW  upstream word.
in_ready  output  1  word accepted this cycle when in_valid is also high; combinational.
out_valid  output  1  out_data holds a valid word; registered.
out_data  output  DW  output word; registered.
out_ready  input  1  downstream accepts out_data.
ram_level  output  AW+1  words held in RAM, 0..DEPTH; excludes the output slot; registered.
ram_enb  output  1  to RAM enb; 1=write, 0=read.
ram_addr  output  AW  to RAM addr.
ram_wdata  output  DW  to RAM w_data.
ram_rdata  input  DW  from RAM r_data; valid in the same cycle when ram_enb=0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low.
- State: wr_ptr[AW], rd_ptr[AW], ram_level, out_valid, out_data, last_gnt (0=read, 1=write).
- Reset values: all pointers 0, ram_level 0, out_valid 0, out_data 0, last_gnt 0.
- Mid-operation reset: all state clears immediately and buffered data is discarded. The RAM is cleared by its own reset.
- Combinational terms:
  - slot_free = !out_valid | out_ready.
  - want_rd = (ram_level != 0) & slot_free.
  - full = (ram_level == DEPTH).
- Grant:
  - rd_sel = want_rd & (!in_valid | full | last_gnt==1).
  - wr_sel = in_valid & !full & !rd_sel.
- in_ready = !full & !rd_sel.
- RAM drive:
  - wr_sel: ram_enb=1, ram_addr=wr_ptr, ram_wdata=in_data.
  - Otherwise: ram_enb=0, ram_addr=rd_ptr, ram_wdata=0. An idle cycle is a harmless read.
- On wr_sel (clock edge): wr_ptr+1, wrapping 127->0. ram_level+1. last_gnt<=1.
- On rd_sel (clock edge): out_data<=ram_rdata, out_valid<=1, rd_ptr+1 with wrap, ram_level-1, last_gnt<=0.
- Neither selected: if out_valid & out_ready, out_valid<=0. last_gnt holds.
- Out slot while out_valid & !out_ready: out_data stable, no read issued.
- Read and write never occur in the same cycle; ram_level changes by at most ±1.
- Latency: a word written at cycle N on an empty RAM gets rd_sel at N+1, because last_gnt=1 makes read win a tie. out_valid is high at N+2.
- Sustained throughput with both sides active: 1 word per 2 cycles, strictly alternating.
- Full: in_ready=0. Reads continue and free space the following cycle.
- Empty with free slot: no read. out_valid drops after consumption.
- Pointer wrap: AW-bit natural overflow. Level derives only from ram_level, never from pointer compare.
- No overflow or underflow is possible by construction. Assertions must flag ram_level>DEPTH and any read with ram_level==0.

Decomposition:
- Package spram_fifo_pkg: AW, DW, DEPTH constants; gnt_t enum {GNT_RD=0, GNT_WR=1} for last_gnt.
- One sub-module, spram_rr_arb2: combinational 2-way round-robin on (want_rd, in_valid&!full, last_gnt). Outputs rd_sel and wr_sel.
- The RAM itself is instantiated beside this block at the next level up, not inside it.

Test Plan:
- Reset: hold rst=0 with random inputs, then release. Required: out_valid=0, out_data=0, ram_level=0, in_ready=1, ram_enb=0, ram_addr=0.
- Single word: send 4'hA at cycle 0. Required: ram_enb=1 and addr=0 at cycle 0; out_valid=1 and out_data=4'hA at cycle 2; ram_level 1 then 0.
- Fill with out_ready=0: send 129 words. Required: in_ready=0 once ram_level=128. Draining returns the words in order, with wr_ptr wrapped 127->0.
- Simultaneous stream: in_valid=1 and out_ready=1 continuously on 0,1,2,... Required: ram_enb alternates 1,0,1,0; one output every 2 cycles; sequence intact.
- Backpressure: out_valid=1 with out_ready=0 for 10 cycles. Required: out_data stable, rd_ptr unchanged, writes continue every cycle.
- Mid-stream reset: assert rst with ram_level=50. Required: everything returns to reset values; next input 4'h5 is the first output.
